// File: rtl/cdp_pkg.sv
// cdp_pkg: shared definitions for the Core Debug Port (CDP) command path.
// The CDP JTAG port and cdp_bus_bridge import this package. It holds the
// op codes, the ACK encodings, the SELECT bit positions and the bridge FSM
// state type.
package cdp_pkg;

  // CDPACC op codes. Values 3..7 are reserved.
  localparam logic [2:0] CDP_SELECT = 3'd0;
  localparam logic [2:0] CDP_TADDR  = 3'd1;
  localparam logic [2:0] CDP_DTR    = 3'd2;

  // ACK values returned to the JTAG side on Capture-DR.
  localparam logic [3:0] CDP_ACK_OK    = 4'b0010;
  localparam logic [3:0] CDP_ACK_WAIT  = 4'b0001;
  localparam logic [3:0] CDP_ACK_FAULT = 4'b0100;

  // SELECT register bit positions.
  localparam int CDP_SEL_AUTOINC   = 0;
  localparam int CDP_SEL_FAULT_CLR = 31;  // write-1-to-clear; never stored

  typedef enum logic [1:0] {
    CDP_ST_IDLE = 2'd0,
    CDP_ST_XFER = 2'd1,
    CDP_ST_DONE = 2'd2
  } cdp_state_e;

  // ACK priority: FAULT, then WAIT, then OK.
  function automatic logic [3:0] cdp_ack_encode(input logic fault, input logic busy);
    if (fault)     return CDP_ACK_FAULT;
    else if (busy) return CDP_ACK_WAIT;
    else           return CDP_ACK_OK;
  endfunction

endpackage

// File: rtl/cdp_bus_timeout.sv
// cdp_bus_timeout: bus transaction watchdog.
//   tck, trst_n : clock and asynchronous active-low reset
//   clear       : zero the count (held while no transaction is in flight)
//   enable      : count one bus cycle
//   expired     : high during the TIMEOUT-th enabled cycle since the last clear
// The count saturates once expired.
module cdp_bus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic tck,
  input  logic trst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  // The count holds the number of cycles already spent. A count of TIMEOUT-1
  // therefore means the current cycle is the last one allowed.
  assign expired = (count_reg == LAST);

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/cdp_bus_bridge.sv
// cdp_bus_bridge: executes decoded CDPACC commands on the debug memory bus.
//   tck, trst_n           : test clock, asynchronous active-low reset
//   cmd_valid/wr/op/data  : one command per cmd_valid strobe
//   bus_req/we/addr/wdata : bus request. These are held stable until bus_ready.
//   bus_ready/rdata/err   : bus response. It is sampled only while bus_req is high.
//   cdp_result            : result of the last completed command
//   cdp_ack               : OK / WAIT / FAULT status
// The block holds the SELECT (AUTOINC), TADDR and DTR registers, a sticky
// FAULT bit and a sticky WAIT bit.
module cdp_bus_bridge
  import cdp_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        tck,
  input  logic        trst_n,
  input  logic        cmd_valid,
  input  logic        cmd_wr,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic [31:0] cdp_result,
  output logic [3:0]  cdp_ack
);

  cdp_state_e  state_reg;
  logic        autoinc_reg;
  logic        fault_reg;
  logic        sticky_wait_reg;
  logic [31:0] taddr_reg;
  logic [31:0] dtr_reg;
  logic [31:0] result_reg;
  logic        bus_req_reg;
  logic        bus_we_reg;
  logic [31:0] bus_addr_reg;
  logic [31:0] bus_wdata_reg;

  logic expired;
  logic bus_done;

  cdp_bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .tck     (tck),
    .trst_n  (trst_n),
    .clear   (state_reg != CDP_ST_XFER),
    .enable  (state_reg == CDP_ST_XFER),
    .expired (expired)
  );

  // A ready that arrives without an outstanding request is ignored.
  assign bus_done = bus_req_reg && bus_ready;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_reg       <= CDP_ST_IDLE;
      autoinc_reg     <= 1'b0;
      fault_reg       <= 1'b0;
      sticky_wait_reg <= 1'b0;
      taddr_reg       <= '0;
      dtr_reg         <= '0;
      result_reg      <= '0;
      bus_req_reg     <= 1'b0;
      bus_we_reg      <= 1'b0;
      bus_addr_reg    <= '0;
      bus_wdata_reg   <= '0;
    end else begin
      // A command that arrives while a transaction is in flight is dropped.
      // The host learns about it through the sticky WAIT bit.
      if (cmd_valid && (state_reg != CDP_ST_IDLE)) begin
        sticky_wait_reg <= 1'b1;
      end

      case (state_reg)
        CDP_ST_IDLE: begin
          if (cmd_valid) begin
            sticky_wait_reg <= 1'b0;
            case (cmd_op)
              CDP_SELECT: begin
                if (cmd_wr) begin
                  autoinc_reg <= cmd_data[CDP_SEL_AUTOINC];
                  if (cmd_data[CDP_SEL_FAULT_CLR]) fault_reg <= 1'b0;
                end else begin
                  result_reg <= {31'b0, autoinc_reg};
                end
              end
              CDP_TADDR: begin
                if (cmd_wr) taddr_reg  <= cmd_data;
                else        result_reg <= taddr_reg;
              end
              CDP_DTR: begin
                // While FAULT is set, a DTR access is absorbed without bus activity.
                if (!fault_reg) begin
                  if (cmd_wr) dtr_reg <= cmd_data;
                  bus_req_reg  <= 1'b1;
                  bus_we_reg   <= cmd_wr;
                  bus_addr_reg <= taddr_reg;
                  // wdata is don't-care on reads. Presenting DTR keeps it meaningful.
                  bus_wdata_reg <= cmd_wr ? cmd_data : dtr_reg;
                  state_reg    <= CDP_ST_XFER;
                end
              end
              default: begin
                if (!cmd_wr) result_reg <= '0;
              end
            endcase
          end
        end

        CDP_ST_XFER: begin
          // A response takes priority over expiry on the last allowed cycle.
          if (bus_done) begin
            bus_req_reg <= 1'b0;
            if (bus_err) begin
              fault_reg <= 1'b1;
            end else if (!bus_we_reg) begin
              dtr_reg    <= bus_rdata;
              result_reg <= bus_rdata;
            end
            state_reg <= CDP_ST_DONE;
          end else if (expired) begin
            bus_req_reg <= 1'b0;
            fault_reg   <= 1'b1;
            state_reg   <= CDP_ST_DONE;
          end
        end

        CDP_ST_DONE: begin
          // FAULT was clear when the transfer started and nothing else can set
          // it meanwhile. If it is set now, this transfer failed.
          if (autoinc_reg && !fault_reg) taddr_reg <= taddr_reg + 32'd4;
          state_reg <= CDP_ST_IDLE;
        end

        default: state_reg <= CDP_ST_IDLE;
      endcase
    end
  end

  assign bus_req    = bus_req_reg;
  assign bus_we     = bus_we_reg;
  assign bus_addr   = bus_addr_reg;
  assign bus_wdata  = bus_wdata_reg;
  assign cdp_result = result_reg;
  // ACK is decoded from registered state. It therefore changes on the same
  // cycle boundary as the FSM, and returns to OK in the IDLE cycle.
  assign cdp_ack = cdp_ack_encode(fault_reg,
                                  (state_reg != CDP_ST_IDLE) || sticky_wait_reg);

endmodule

// File: tb/tb_cdp_bus_bridge.sv
module tb_cdp_bus_bridge;
  import cdp_pkg::*;

  localparam int TO = 4;

  logic        tck = 1'b0;
  logic        trst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_err = 1'b0;
  logic [31:0] cdp_result;
  logic [3:0]  cdp_ack;

  cdp_bus_bridge #(.TIMEOUT(TO)) dut (
    .tck        (tck),
    .trst_n     (trst_n),
    .cmd_valid  (cmd_valid),
    .cmd_wr     (cmd_wr),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err),
    .cdp_result (cdp_result),
    .cdp_ack    (cdp_ack)
  );

  always #5 tck = ~tck;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference state.
  logic        m_autoinc;
  logic        m_fault;
  logic        m_sticky;
  logic [31:0] m_taddr;
  logic [31:0] m_result;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_ack(input logic busy);
    if (m_fault)             return 32'(CDP_ACK_FAULT);
    else if (busy || m_sticky) return 32'(CDP_ACK_WAIT);
    else                     return 32'(CDP_ACK_OK);
  endfunction

  task automatic model_reset();
    m_autoinc = 1'b0;
    m_fault   = 1'b0;
    m_sticky  = 1'b0;
    m_taddr   = 32'd0;
    m_result  = 32'd0;
  endtask

  // Issues one command from a negedge and plays the bus slave.
  // wt   : wait cycles before bus_ready (wt >= TO means a timeout)
  // poke : fire an extra command during the transfer, which must be dropped
  task automatic do_cmd(input logic wr, input logic [2:0] op, input logic [31:0] data,
                        input int wt, input logic err, input logic [31:0] rd,
                        input logic poke);
    int  high;
    bit  done;
    bit  go;
    bit  tmo;
    logic [31:0] addr_exp;
    go = (op == CDP_DTR) && !m_fault;
    addr_exp = m_taddr;
    $display("CMD wr=%0d op=%0d data=%h wait=%0d err=%0d poke=%0d", wr, op, data, wt, err, poke);
    cmd_wr = wr; cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    @(negedge tck);
    cmd_valid = 1'b0;
    m_sticky = 1'b0;
    if (!go) begin
      if (wr) begin
        if (op == CDP_SELECT) begin
          m_autoinc = data[0];
          if (data[31]) m_fault = 1'b0;
        end else if (op == CDP_TADDR) begin
          m_taddr = data;
        end
      end else begin
        if (op == CDP_SELECT)     m_result = {31'b0, m_autoinc};
        else if (op == CDP_TADDR) m_result = m_taddr;
        else if (op != CDP_DTR)   m_result = 32'd0;
      end
      chk("noreq", 32'(bus_req), 32'd0);
      chk("result", cdp_result, m_result);
      chk("ack", 32'(cdp_ack), exp_ack(1'b0));
    end else begin
      high = 0;
      done = 0;
      for (int c = 0; c < TO + 12 && !done; c++) begin
        if (bus_req) begin
          high++;
          if (high == 1) begin
            chk("bus_addr", bus_addr, addr_exp);
            chk("bus_we", 32'(bus_we), 32'(wr));
            if (wr) chk("bus_wdata", bus_wdata, data);
            if (poke) begin
              cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_op = CDP_TADDR; cmd_data = $urandom();
            end
          end
          if (high == wt + 1) begin
            bus_ready = 1'b1; bus_err = err; bus_rdata = rd;
          end
          @(negedge tck);
          cmd_valid = 1'b0; bus_ready = 1'b0; bus_err = 1'b0;
        end else if (high > 0) begin
          done = 1;
        end else begin
          @(negedge tck);
        end
      end
      if (poke) m_sticky = 1'b1;
      tmo = (wt + 1 > TO);
      chk("req_cycles", 32'(high), tmo ? 32'(TO) : 32'(wt + 1));
      chk("done_seen", 32'(done), 32'd1);
      if (tmo || err) begin
        m_fault = 1'b1;
      end else begin
        if (!wr) m_result = rd;
        if (m_autoinc) m_taddr = m_taddr + 32'd4;
      end
      chk("ack_done", 32'(cdp_ack), exp_ack(1'b1));
      @(negedge tck);
      chk("ack_idle", 32'(cdp_ack), exp_ack(1'b0));
      chk("result", cdp_result, m_result);
      chk("req_low", 32'(bus_req), 32'd0);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge tck);
    trst_n = 1'b1;
    @(negedge tck);
    $display("RESET state");
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_result", cdp_result, 32'd0);
    chk("rst_ack", 32'(cdp_ack), 32'(CDP_ACK_OK));

    // Register access
    do_cmd(1'b1, CDP_TADDR, 32'h1000, 0, 1'b0, 32'd0, 1'b0);
    do_cmd(1'b0, CDP_TADDR, 32'd0, 0, 1'b0, 32'd0, 1'b0);
    // Read with auto-increment, two wait cycles
    do_cmd(1'b1, CDP_SELECT, 32'd1, 0, 1'b0, 32'd0, 1'b0);
    do_cmd(1'b1, CDP_TADDR, 32'h100, 0, 1'b0, 32'd0, 1'b0);
    do_cmd(1'b0, CDP_DTR, 32'd0, 2, 1'b0, 32'hDEADBEEF, 1'b0);
    do_cmd(1'b0, CDP_TADDR, 32'd0, 0, 1'b0, 32'd0, 1'b0);
    do_cmd(1'b0, CDP_SELECT, 32'd0, 0, 1'b0, 32'd0, 1'b0);
    // Write, no auto-increment, zero-wait
    do_cmd(1'b1, CDP_SELECT, 32'd0, 0, 1'b0, 32'd0, 1'b0);
    do_cmd(1'b1, CDP_DTR, 32'h55AA, 0, 1'b0, 32'd0, 1'b0);
    do_cmd(1'b0, CDP_TADDR, 32'd0, 0, 1'b0, 32'd0, 1'b0);
    // Busy and WAIT, then the next accepted command returns OK
    do_cmd(1'b0, CDP_DTR, 32'd0, 2, 1'b0, 32'h12345678, 1'b1);
    do_cmd(1'b0, CDP_TADDR, 32'd0, 0, 1'b0, 32'd0, 1'b0);
    // Error, FAULT blocks DTR, FAULT clear
    do_cmd(1'b0, CDP_DTR, 32'd0, 1, 1'b1, 32'hCAFEF00D, 1'b0);
    do_cmd(1'b0, CDP_DTR, 32'd0, 0, 1'b0, 32'd0, 1'b0);
    do_cmd(1'b1, CDP_SELECT, 32'h80000000, 0, 1'b0, 32'd0, 1'b0);
    do_cmd(1'b0, CDP_DTR, 32'd0, 0, 1'b0, 32'h0BADC0DE, 1'b0);
    // Timeout, and bus_ready on the last allowed cycle
    do_cmd(1'b0, CDP_DTR, 32'd0, 10, 1'b0, 32'd0, 1'b0);
    do_cmd(1'b1, CDP_SELECT, 32'h80000001, 0, 1'b0, 32'd0, 1'b0);
    do_cmd(1'b0, CDP_DTR, 32'd0, TO - 1, 1'b0, 32'h600DD00D, 1'b0);
    // Reserved op
    do_cmd(1'b0, 3'd5, 32'd0, 0, 1'b0, 32'd0, 1'b0);

    // bus_ready without bus_req is ignored
    $display("IDLE bus_ready pulse");
    bus_ready = 1'b1; bus_rdata = 32'hFFFF0000; bus_err = 1'b1;
    repeat (3) @(negedge tck);
    bus_ready = 1'b0; bus_err = 1'b0;
    chk("stray_req", 32'(bus_req), 32'd0);
    chk("stray_result", cdp_result, m_result);
    chk("stray_ack", 32'(cdp_ack), exp_ack(1'b0));

    // trst_n during XFER
    $display("RESET during XFER");
    cmd_wr = 1'b0; cmd_op = CDP_DTR; cmd_valid = 1'b1;
    @(negedge tck);
    cmd_valid = 1'b0;
    chk("pre_rst_req", 32'(bus_req), 32'd1);
    #2 trst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_req", 32'(bus_req), 32'd0);
    chk("arst_we", 32'(bus_we), 32'd0);
    chk("arst_addr", bus_addr, 32'd0);
    chk("arst_wdata", bus_wdata, 32'd0);
    chk("arst_result", cdp_result, 32'd0);
    chk("arst_ack", 32'(cdp_ack), 32'(CDP_ACK_OK));
    @(negedge tck);
    bus_ready = 1'b1; bus_rdata = 32'h13579BDF; trst_n = 1'b1;
    repeat (2) @(negedge tck);
    bus_ready = 1'b0;
    chk("post_rst_req", 32'(bus_req), 32'd0);
    chk("post_rst_result", cdp_result, 32'd0);
    chk("post_rst_ack", 32'(cdp_ack), 32'(CDP_ACK_OK));
    do_cmd(1'b0, CDP_TADDR, 32'd0, 0, 1'b0, 32'd0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      logic        r_wr;
      logic [2:0]  r_op;
      logic [31:0] r_data;
      int          r_wt;
      logic        r_err;
      logic        r_poke;
      r_wr   = 1'($urandom_range(0, 1));
      r_op   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      r_data = $urandom();
      if (r_op == CDP_SELECT && $urandom_range(0, 1) == 1) r_data[31] = 1'b1;
      r_wt   = $urandom_range(0, 5);
      r_err  = ($urandom_range(0, 7) == 0);
      r_poke = ($urandom_range(0, 3) == 0);
      do_cmd(r_wr, r_op, r_data, r_wt, r_err, $urandom(), r_poke);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
